// File: rtl/capture_pkg.sv
// Shared types and constants for the audio capture burst controller.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    BURST,
    DONE
  } state_t;

  localparam int unsigned BYTES_PER_WORD     = 4;
  localparam int unsigned DEFAULT_BURST_LEN  = 4;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 8;

  // Beats for the next burst: a full burst, or whatever is left of the run.
  function automatic logic [2:0] burst_beats(input logic [31:0] remaining,
                                             input int unsigned burst_len);
    if (remaining >= 32'(burst_len)) return 3'(burst_len);
    return remaining[2:0];
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Sample FIFO between the read_ready strobe side and the Avalon-MM burst side.
module capture_fifo
  import capture_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ == (AW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign count   = occ;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries no reset; pointers and occupancy define validity.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/capture_burst_ctrl.sv
// Captures strobed microphone samples into a FIFO and writes them to memory
// as Avalon-MM write bursts of up to BURST_LEN beats.
module capture_burst_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned BURST_LEN  = DEFAULT_BURST_LEN,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        read_ready,
  input  logic [31:0] mic_data,
  input  logic [31:0] start_address,
  input  logic [31:0] number_samples,
  output logic [31:0] AM_ADDR,
  output logic [2:0]  AM_BURSTCOUNT,
  output logic        AM_WRITE,
  output logic [31:0] AM_WRITEDATA,
  output logic [3:0]  AM_BYTEENABLE,
  input  logic        AM_WAITREQUEST,
  output logic        FINISHED,
  output logic        BUSY,
  output logic        OVERFLOW
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t          state;
  logic            rr_prev;
  logic            rise;
  logic            want_push;
  logic            push;
  logic            drop;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [31:0]     fifo_head;
  logic [31:0]     total;
  logic [31:0]     pushed;
  logic [31:0]     remaining;
  logic [2:0]      beats_left;
  logic [2:0]      next_burst;
  logic [31:0]     addr;
  logic [2:0]      burstcount;
  logic            am_write;
  logic [3:0]      byteenable;
  logic            finished;
  logic            busy;
  logic            overflow;

  assign rise       = read_ready && !rr_prev;
  // busy is high exactly in COLLECT/BURST, so it doubles as the accept window.
  assign want_push  = rise && busy && (pushed != total);
  assign push       = want_push && !fifo_full;
  assign drop       = want_push && fifo_full;
  assign pop        = am_write && !AM_WAITREQUEST && !fifo_empty;
  assign next_burst = burst_beats(remaining, BURST_LEN);

  capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push),
    .pop   (pop),
    .din   (mic_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      rr_prev    <= 1'b0;
      total      <= '0;
      pushed     <= '0;
      remaining  <= '0;
      beats_left <= '0;
      addr       <= '0;
      burstcount <= '0;
      am_write   <= 1'b0;
      byteenable <= '0;
      finished   <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rr_prev <= read_ready;
      if (push) pushed   <= pushed + 32'd1;
      if (drop) overflow <= 1'b1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            addr      <= start_address & ~32'h3;
            total     <= number_samples;
            remaining <= number_samples;
            pushed    <= '0;
            overflow  <= 1'b0;
            if (number_samples == '0) begin
              state    <= DONE;
              finished <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state    <= COLLECT;
              finished <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end

        COLLECT: begin
          // Enough data buffered for the whole burst, so beats never starve.
          if (32'(fifo_count) >= 32'(next_burst)) begin
            state      <= BURST;
            am_write   <= 1'b1;
            byteenable <= '1;
            burstcount <= next_burst;
            beats_left <= next_burst;
          end
        end

        BURST: begin
          if (pop) begin
            remaining <= remaining - 32'd1;
            if (beats_left == 3'd1) begin
              addr       <= addr + 32'(BYTES_PER_WORD) * 32'(burstcount);
              am_write   <= 1'b0;
              byteenable <= '0;
              burstcount <= '0;
              beats_left <= '0;
              if (remaining == 32'd1) begin
                state    <= DONE;
                finished <= 1'b1;
                busy     <= 1'b0;
              end else begin
                state <= COLLECT;
              end
            end else begin
              beats_left <= beats_left - 3'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign AM_ADDR       = addr;
  assign AM_BURSTCOUNT = burstcount;
  assign AM_WRITE      = am_write;
  assign AM_BYTEENABLE = byteenable;
  assign AM_WRITEDATA  = am_write ? fifo_head : '0;
  assign FINISHED      = finished;
  assign BUSY          = busy;
  assign OVERFLOW      = overflow;

endmodule

// File: tb/tb_capture_burst_ctrl.sv
// Randomized and directed checks of capture_burst_ctrl against a beat-level
// reference model (expected address/count/data derived per sample index).
module tb_capture_burst_ctrl;

  localparam int unsigned BL = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic        read_ready = 1'b0;
  logic        AM_WAITREQUEST = 1'b0;
  logic [31:0] mic_data = '0;
  logic [31:0] start_address = '0;
  logic [31:0] number_samples = '0;
  logic [31:0] AM_ADDR;
  logic [31:0] AM_WRITEDATA;
  logic [2:0]  AM_BURSTCOUNT;
  logic        AM_WRITE;
  logic [3:0]  AM_BYTEENABLE;
  logic        FINISHED;
  logic        BUSY;
  logic        OVERFLOW;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  bc;
    logic [31:0] data;
  } beat_t;

  beat_t       beats[$];
  logic [31:0] acc[$];

  always #5 CLK = ~CLK;

  capture_burst_ctrl #(
    .BURST_LEN  (4),
    .FIFO_DEPTH (8)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .start          (start),
    .read_ready     (read_ready),
    .mic_data       (mic_data),
    .start_address  (start_address),
    .number_samples (number_samples),
    .AM_ADDR        (AM_ADDR),
    .AM_BURSTCOUNT  (AM_BURSTCOUNT),
    .AM_WRITE       (AM_WRITE),
    .AM_WRITEDATA   (AM_WRITEDATA),
    .AM_BYTEENABLE  (AM_BYTEENABLE),
    .AM_WAITREQUEST (AM_WAITREQUEST),
    .FINISHED       (FINISHED),
    .BUSY           (BUSY),
    .OVERFLOW       (OVERFLOW)
  );

  // Log every accepted beat as the slave sees it.
  always @(posedge CLK) begin
    if (RESET === 1'b1 && AM_WRITE === 1'b1 && AM_WAITREQUEST === 1'b0)
      beats.push_back('{AM_ADDR, AM_BURSTCOUNT, AM_WRITEDATA});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input int unsigned wr_pct);
    AM_WAITREQUEST = ($urandom_range(99, 0) < wr_pct);
    tick();
  endtask

  task automatic pulse(input logic [31:0] d);
    mic_data   = d;
    read_ready = 1'b1;
    tick();
    read_ready = 1'b0;
    tick();
  endtask

  task automatic wait_finished(input int unsigned wr_pct);
    int unsigned k;
    k = 0;
    while (FINISHED !== 1'b1 && k < 400) begin
      step(wr_pct);
      k++;
    end
    AM_WAITREQUEST = 1'b0;
    chk("finished", FINISHED, 1);
  endtask

  // Sample k lands in burst k/BL at base + 16*(k/BL); that burst's length is
  // min(BL, samples left when it starts).
  task automatic check_beats(input logic [31:0] a, input int unsigned n,
                             input int unsigned exp_cnt);
    int unsigned lim;
    int unsigned b;
    int unsigned first;
    int unsigned ebc;
    logic [31:0] ea;
    chk("beat_count", 32'(beats.size()), exp_cnt);
    lim = (beats.size() < exp_cnt) ? beats.size() : exp_cnt;
    for (int unsigned k = 0; k < lim; k++) begin
      b     = k / BL;
      first = b * BL;
      ea    = (a & ~32'h3) + 32'(4 * BL * b);
      ebc   = ((n - first) < BL) ? (n - first) : BL;
      chk("beat_addr", beats[k].addr, ea);
      chk("beat_burstcount", 32'(beats[k].bc), ebc);
      chk("beat_data", beats[k].data, acc[k]);
    end
  endtask

  task automatic run(input logic [31:0] a, input int unsigned n, input int unsigned edges,
                     input int unsigned hi_len, input int unsigned wr_pct);
    logic [31:0] d;
    beats.delete();
    acc.delete();
    AM_WAITREQUEST = 1'b0;
    start_address  = a;
    number_samples = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", BUSY, 1);
    chk("finished_cleared", FINISHED, 0);
    for (int unsigned e = 0; e < edges; e++) begin
      d = $urandom;
      mic_data   = d;
      read_ready = 1'b1;
      repeat ((hi_len != 0) ? hi_len : $urandom_range(3, 1)) step(wr_pct);
      read_ready = 1'b0;
      mic_data   = $urandom;
      if (acc.size() < n) acc.push_back(d);
      if (e == 0 && n >= 2) begin
        start_address  = $urandom;
        number_samples = $urandom_range(50, 1);
        start = 1'b1;
      end
      step(wr_pct);
      start = 1'b0;
      repeat ($urandom_range(2, 0)) step(wr_pct);
    end
    wait_finished(wr_pct);
    chk("busy_done", BUSY, 0);
    chk("write_idle", AM_WRITE, 0);
    chk("byteenable_idle", AM_BYTEENABLE, 0);
    chk("overflow_clear", OVERFLOW, 0);
    check_beats(a, n, n);
  endtask

  initial begin
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] d0;
    logic [31:0] d;
    int unsigned k;
    int unsigned n;

    #2 RESET = 1'b0;
    #10;
    chk("rst_addr", AM_ADDR, 0);
    chk("rst_burstcount", AM_BURSTCOUNT, 0);
    chk("rst_write", AM_WRITE, 0);
    chk("rst_writedata", AM_WRITEDATA, 0);
    chk("rst_byteenable", AM_BYTEENABLE, 0);
    chk("rst_finished", FINISHED, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_overflow", OVERFLOW, 0);
    RESET = 1'b1;
    tick();

    // Zero-length run goes straight to DONE.
    beats.delete();
    start_address  = 32'h400;
    number_samples = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_finished", FINISHED, 1);
    chk("zero_busy", BUSY, 0);
    repeat (3) pulse($urandom);
    chk("zero_no_beats", 32'(beats.size()), 0);
    chk("zero_write", AM_WRITE, 0);

    run(32'h100, 8, 8, 0, 0);
    run(32'h100, 6, 7, 0, 0);
    run(32'h103, 2, 2, 5, 0);

    // Stall on beat 2 for three cycles.
    beats.delete();
    acc.delete();
    AM_WAITREQUEST = 1'b0;
    start_address  = 32'h200;
    number_samples = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int unsigned e = 0; e < 4; e++) begin
      d = $urandom;
      acc.push_back(d);
      pulse(d);
    end
    k = 0;
    while (AM_WRITE !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("stall_write_seen", AM_WRITE, 1);
    tick();
    AM_WAITREQUEST = 1'b1;
    a0 = AM_ADDR;
    b0 = 32'(AM_BURSTCOUNT);
    d0 = AM_WRITEDATA;
    chk("stall_beat2_data", d0, acc[1]);
    for (int unsigned c = 0; c < 3; c++) begin
      tick();
      chk("stall_addr", AM_ADDR, a0);
      chk("stall_burstcount", 32'(AM_BURSTCOUNT), b0);
      chk("stall_data", AM_WRITEDATA, d0);
      chk("stall_write", AM_WRITE, 1);
    end
    AM_WAITREQUEST = 1'b0;
    wait_finished(0);
    check_beats(32'h200, 4, 4);
    chk("addr_advanced", AM_ADDR, 32'h210);

    // Overflow while the slave stalls.
    beats.delete();
    acc.delete();
    AM_WAITREQUEST = 1'b1;
    start_address  = 32'h300;
    number_samples = 16;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int unsigned e = 0; e < 9; e++) begin
      d = $urandom;
      if (e < 8) acc.push_back(d);
      pulse(d);
      if (e == 7) chk("ovf_before_9th", OVERFLOW, 0);
    end
    chk("ovf_after_9th", OVERFLOW, 1);
    chk("ovf_no_beats_stalled", 32'(beats.size()), 0);
    AM_WAITREQUEST = 1'b0;
    k = 0;
    while (beats.size() < 8 && k < 60) begin
      tick();
      k++;
    end
    repeat (5) tick();
    check_beats(32'h300, 16, 8);
    chk("ovf_busy_mid", BUSY, 1);
    chk("ovf_not_finished", FINISHED, 0);
    for (int unsigned e = 0; e < 8; e++) begin
      d = $urandom;
      acc.push_back(d);
      pulse(d);
    end
    wait_finished(0);
    check_beats(32'h300, 16, 16);
    chk("ovf_sticky", OVERFLOW, 1);

    // Reset in the middle of a stalled burst.
    beats.delete();
    AM_WAITREQUEST = 1'b1;
    start_address  = 32'h500;
    number_samples = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) pulse($urandom);
    k = 0;
    while (AM_WRITE !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("rstmid_write_seen", AM_WRITE, 1);
    RESET = 1'b0;
    #1;
    chk("rstmid_addr", AM_ADDR, 0);
    chk("rstmid_burstcount", AM_BURSTCOUNT, 0);
    chk("rstmid_write", AM_WRITE, 0);
    chk("rstmid_writedata", AM_WRITEDATA, 0);
    chk("rstmid_byteenable", AM_BYTEENABLE, 0);
    chk("rstmid_busy", BUSY, 0);
    chk("rstmid_finished", FINISHED, 0);
    #2 RESET = 1'b1;
    AM_WAITREQUEST = 1'b0;
    repeat (5) tick();
    chk("post_rst_write", AM_WRITE, 0);
    chk("post_rst_busy", BUSY, 0);
    chk("post_rst_finished", FINISHED, 0);
    chk("post_rst_no_beats", 32'(beats.size()), 0);

    for (int unsigned r = 0; r < 5; r++) begin
      n = $urandom_range(20, 1);
      run($urandom, n, n + $urandom_range(2, 0), 0, 25);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/capture_burst_ctrl.md
CAPTURE_BURST_CTRL -- requirements
Module: capture_burst_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, maximum beats per Avalon-MM write burst (1..4).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, sample FIFO entries (power of 2, >= BURST_LEN).
REQ-003 SHALL have ports:
- CLK  input  1  sole clock.
- RESET  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a capture run.
- read_ready  input  1  sample strobe; one sample per rising edge.
- mic_data  input  32  sample word, valid while read_ready is high.
- start_address  input  32  byte address of first sample, latched on accepted start.
- number_samples  input  32  samples to capture, latched on accepted start.
- AM_ADDR  output  32  Avalon-MM byte address of the burst.
- AM_BURSTCOUNT  output  3  beats in the current burst.
- AM_WRITE  output  1  write request.
- AM_WRITEDATA  output  32  beat data.
- AM_BYTEENABLE  output  4  byte lanes.
- AM_WAITREQUEST  input  1  slave stall.
- FINISHED  output  1  run complete, level.
- BUSY  output  1  run in progress.
- OVERFLOW  output  1  sticky; a sample was dropped this run.

Function
REQ-004 SHALL implement FSM states IDLE, COLLECT, BURST, DONE.
REQ-005 IDLE/DONE: start=1 SHALL latch start_address with bits [1:0] forced to 0, latch number_samples, clear OVERFLOW and FINISHED, and go to COLLECT; if number_samples==0, SHALL instead go to DONE and set FINISHED next cycle.
REQ-006 start in COLLECT or BURST SHALL be ignored.
REQ-007 read_ready SHALL be edge-detected (registered previous value); a rising edge in COLLECT or BURST SHALL push mic_data into the FIFO, one push per edge regardless of high duration.
REQ-008 Edges in IDLE or DONE SHALL be ignored; an edge once pushed+written count equals number_samples SHALL be ignored.
REQ-009 A push with the FIFO full SHALL drop the sample, set OVERFLOW, and not count it.
REQ-010 COLLECT -> BURST when FIFO occupancy >= B, B = min(BURST_LEN, samples remaining to write); B latched into AM_BURSTCOUNT at entry.
REQ-011 In BURST: AM_WRITE=1, AM_BYTEENABLE=4'hF, AM_ADDR and AM_BURSTCOUNT constant for the whole burst; AM_WRITEDATA = FIFO head.
REQ-012 A beat SHALL complete on a cycle with AM_WRITE=1 and AM_WAITREQUEST=0; completion pops the FIFO and decrements remaining by 1; while AM_WAITREQUEST=1 all master outputs SHALL hold.
REQ-013 After the last beat, AM_ADDR SHALL advance by 4*B (32-bit wrap-around permitted) and FSM SHALL go to COLLECT, or to DONE if remaining==0.
REQ-014 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-015 DONE: FINISHED=1, BUSY=0, held until next accepted start.
REQ-016 BUSY SHALL be 1 exactly in COLLECT and BURST.
REQ-017 Outside BURST: AM_WRITE=0, AM_BYTEENABLE=0, AM_BURSTCOUNT=0.

Reset
REQ-018 RESET low SHALL asynchronously force IDLE, empty FIFO, AM_ADDR=0, AM_BURSTCOUNT=0, AM_WRITE=0, AM_WRITEDATA=0, AM_BYTEENABLE=0, FINISHED=0, BUSY=0, OVERFLOW=0, edge register=0.
REQ-019 Reset asserted mid-burst SHALL abort the burst immediately; no resumption after release.

Structure
REQ-020 Package capture_pkg SHALL hold the FSM state enum, BYTES_PER_WORD=4, and default BURST_LEN/FIFO_DEPTH constants.
REQ-021 The FIFO SHALL be sub-module capture_fifo (push, pop, full, empty, count), same CLK/RESET.

Verification
REQ-022 start_address=0x100, number_samples=8, 8 edges, AM_WAITREQUEST=0 -> two bursts, AM_ADDR 0x100 then 0x110, AM_BURSTCOUNT=4, data in order, FINISHED=1, BUSY=0.
REQ-023 number_samples=6 -> bursts of 4 then 2 (AM_BURSTCOUNT=2 at 0x110); extra 7th edge ignored.
REQ-024 AM_WAITREQUEST high 3 cycles on beat 2 -> AM_ADDR, AM_BURSTCOUNT, AM_WRITEDATA stable throughout; no beat lost or duplicated.
REQ-025 AM_WAITREQUEST held high while 9 edges arrive (number_samples=16) -> OVERFLOW=1 after 9th, only 8 samples written by the time run ends with a later release.
REQ-026 read_ready held high 5 cycles -> exactly one sample pushed; start_address=0x103 -> first AM_ADDR=0x100.
REQ-027 number_samples=0 -> DONE, FINISHED=1, no AM_WRITE; RESET low during burst -> all outputs zero same cycle, IDLE after release.
